seq_alu: RTL

//   Multi-cycle, width-parametrised ALU for the proj3 datapath; successor to the single-cycle 16-bit ALU.

---
 rtl/seq_alu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Multiply and divide are iterative, one bit per cycle (multiply optionally single-cycle).
module seq_alu #(
  parameter int WIDTH    = 16,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [2:0]           op_r;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     div_r;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   prod_fast;
  logic [WIDTH-1:0]     s_res;
  logic [WIDTH-1:0]     s_hi;
  logic                 s_carry;
  logic                 s_err;
  logic                 iterative;

  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_top;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;

  // Single-cycle results, computed straight from the request operands
  always_comb begin
    sum       = {1'b0, rt} + {1'b0, rd};
    diff      = {1'b0, rt} - {1'b0, rd};
    prod_fast = {{WIDTH{1'b0}}, rt} * {{WIDTH{1'b0}}, rd};
    s_res     = '0;
    s_hi      = '0;
    s_carry   = 1'b0;
    s_err     = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        s_res   = sum[WIDTH-1:0];
        s_carry = sum[WIDTH];
      end
      OP_SUB: begin
        s_res   = diff[WIDTH-1:0];
        s_carry = diff[WIDTH];
      end
      OP_AND: s_res = rt & rd;
      OP_OR:  s_res = rt | rd;
      OP_SLT: s_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_MUL: {s_hi, s_res} = prod_fast;
      OP_ILL: s_err = 1'b1;
      default: ;
    endcase
    iterative = (alu_ctrl == OP_DIV) || ((alu_ctrl == OP_MUL) && !FAST_MUL);
  end

  // One iteration step: acc holds {hi, lo} for mul and {remainder, quotient} for div.
  // div_top keeps the bit shifted out of the remainder so the compare is WIDTH+1 wide.
  always_comb begin
    mul_next  = acc + (mplier[0] ? mcand : '0);
    div_top   = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = div_top >= {1'b0, div_r};
    div_next  = {(div_ge ? div_top[WIDTH-1:0] - div_r : div_top[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    iter_next = (op_r == OP_DIV) ? div_next : mul_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
      err         <= 1'b0;
      op_r        <= '0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      div_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= alu_ctrl;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (iterative) begin
              state  <= BUSY;
              acc    <= (alu_ctrl == OP_DIV) ? {{WIDTH{1'b0}}, rt} : '0;
              mcand  <= {{WIDTH{1'b0}}, rt};
              mplier <= rd;
              div_r  <= rd;
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= s_res;
              result_hi   <= s_hi;
              zero        <= (s_res == '0);
              carry       <= s_carry;
              div_by_zero <= 1'b0;
              err         <= s_err;
            end
          end
        end
        BUSY: begin
          acc    <= iter_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration is folded into the DONE transition
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= iter_next[WIDTH-1:0];
            result_hi   <= iter_next[2*WIDTH-1:WIDTH];
            zero        <= (iter_next[WIDTH-1:0] == '0);
            carry       <= 1'b0;
            div_by_zero <= (op_r == OP_DIV) && (div_r == '0);
            err         <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
